// File: rtl/data_mem_responder.sv
// Purpose: valid/ready memory responder; one word request at a time, byte-enabled write or word read on internal RAM.
// Latency: resp_valid rises WAIT_CYCLES+1 edges after the accept edge; request-to-request spacing >= WAIT_CYCLES+3.
// Backpressure: response held stable until resp_ready; req_ready low outside IDLE (requests ignored, not queued).
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_we, req_addr (byte), req_wdata, req_be
//   resp_valid/resp_ready         response handshake; resp_rdata (0 for writes), resp_err
// Optional feature: define MEM_RANGE_CHECK_EN to flag out-of-range or misaligned addresses via resp_err.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic                bad_q, bad_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                req_bad;
    logic                do_write;
    logic                unused_addr_bits;

    // ready_q is registered so it stays low throughout reset and rises on
    // the first edge after release; it is only ever high while in IDLE.
    assign accept     = req_valid & ready_q;
    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef MEM_RANGE_CHECK_EN
    assign req_bad = ((req_addr >> (ADDR_W + 2)) != 32'd0) || (req_addr[1:0] != 2'b00);
`else
    assign req_bad = 1'b0;
`endif

    // Without range checking the bits outside the word index are don't-care.
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        bad_d        = bad_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    idx_d   = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    bad_d   = req_bad;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                err_d        = bad_q;
                rdata_d      = (!we_q && !bad_q) ? mem[idx_q] : 32'd0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    rdata_d      = 32'd0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            bad_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            bad_q        <= bad_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // RAM is not reset. A reset asserted before ACCESS forces state_q to
    // IDLE asynchronously, so the write below can never fire for a dropped request.
    assign do_write = (state_q == S_ACCESS) && we_q && !bad_q;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int AW = 10;
    localparam int WC = 1;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Expected responses: {err, rdata}
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

`ifdef MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per completed response handshake.
    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, mon_e[31:0]);
                chk("resp_err", 32'(resp_err), 32'(mon_e[32]));
            end
        end
    end

    // Issue one request, record the expected response, and check accept-to-valid latency.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk);
        exp_q.push_back({exp_e, exp_d});
        #1;
        // Scramble inputs after acceptance: the latched request must be used.
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(WC + 1));
    endtask

    task automatic finish_resp();
        int n;
        n = 0;
        while (!(resp_valid && resp_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_handshake", 32'(resp_valid & resp_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_be = 4'd0; resp_ready = 1'b1;

        // 1. Reset with req_valid asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; req_valid = 1'b0;
        chk("rel_req_ready_0", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_req_ready_1", 32'(req_ready), 32'd1);

        // 2. Write then read
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0); finish_resp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0); finish_resp();

        // 3. Byte enables, then an all-disabled write
        issue(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'd0, 1'b0); finish_resp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0); finish_resp();
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0); finish_resp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0); finish_resp();

        // 4. Backpressure with a competing request
        resp_ready = 1'b0;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_rdata", resp_rdata, 32'hDEADAAEF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; resp_ready = 1'b1;
        finish_resp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0); finish_resp();

        // 5. Out-of-range write (wraps to word 4 unless range checking is on)
        issue(1'b1, 32'h1010, 32'h12345678, 4'hF, 32'd0, RC); finish_resp();
        issue(1'b0, 32'h10, 32'h0, 4'h0, RC ? 32'hDEADAAEF : 32'h12345678, 1'b0); finish_resp();
        // Misaligned read: truncated to the word, or flagged
        issue(1'b0, 32'h13, 32'h0, 4'h0, RC ? 32'h0 : (RC ? 32'hDEADAAEF : 32'h12345678), RC);
        finish_resp();

        // 6. Reset during WAIT drops a write to 0x20
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0); finish_resp();
        while (!req_ready) begin @(posedge clk); #1; end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        issue(1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0); finish_resp();

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
